// File: rtl/multi_driver_arbiter.sv
// Round-robin arbiter that resolves several candidate drivers into one registered output,
// with hardware detection and counting of cycles where valid drivers disagree on data.
module multi_driver_arbiter #(
  parameter int NUM_DRV = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  localparam int IDW    = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_DRV-1:0]       drv_valid,
  input  logic [NUM_DRV*WIDTH-1:0] drv_data,
  output logic [NUM_DRV-1:0]       drv_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [IDW-1:0]           grant_id,
  output logic                     conflict_pulse,
  output logic                     conflict_sticky,
  output logic [CNT_W-1:0]         conflict_count,
  input  logic                     clear_conflict
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic             pulse_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] data_arr [NUM_DRV];

  for (genvar gi = 0; gi < NUM_DRV; gi++) begin : g_slice
    assign data_arr[gi] = drv_data[gi*WIDTH +: WIDTH];
  end

  logic [2*NUM_DRV-1:0] dbl_valid;
  logic [NUM_DRV-1:0]   rot_valid;
  logic                 found;
  logic [IDW:0]         sum;
  logic [IDW:0]         nxt;
  logic [IDW-1:0]       g;
  logic [IDW-1:0]       rr_after;
  logic                 can_accept;
  logic                 accept;

  // Rotate the request vector so bit 0 is the driver at rr_q, then take the first set bit.
  always_comb begin
    dbl_valid = {drv_valid, drv_valid} >> rr_q;
    rot_valid = dbl_valid[NUM_DRV-1:0];
    found     = 1'b0;
    sum       = '0;
    g         = rr_q;
    for (int k = 0; k < NUM_DRV; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NUM_DRV)) sum = sum - (IDW+1)'(NUM_DRV);
        g     = sum[IDW-1:0];
      end
    end
    nxt = {1'b0, g} + (IDW+1)'(1);
    if (nxt >= (IDW+1)'(NUM_DRV)) nxt = '0;
    rr_after = nxt[IDW-1:0];
  end

  assign can_accept = (state_q == IDLE) || out_ready;
  // Gating with rst_n keeps drv_ready low for the whole time reset is held.
  assign accept     = rst_n && can_accept && found;
  assign drv_ready  = accept ? (NUM_DRV'(1) << g) : '0;

  logic conflict;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_DRV; i++) begin
      for (int j = i + 1; j < NUM_DRV; j++) begin
        if (drv_valid[i] && drv_valid[j] && (data_arr[i] != data_arr[j])) conflict = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    rr_d    = rr_q;
    if (accept) begin
      state_d = FULL;
      data_d  = data_arr[g];
      id_d    = g;
      rr_d    = rr_after;
    end else if (state_q == FULL && out_ready) begin
      state_d = IDLE;
    end
  end

  // A clear coinciding with a conflict restarts the count at one so the event is kept.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clear_conflict) begin
      sticky_d = conflict;
      count_d  = conflict ? CNT_W'(1) : '0;
    end else if (conflict) begin
      sticky_d = 1'b1;
      if (!(&count_q)) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      id_q     <= '0;
      rr_q     <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rr_q     <= rr_d;
      pulse_q  <= conflict;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign out_valid       = (state_q == FULL);
  assign out_data        = data_q;
  assign grant_id        = id_q;
  assign conflict_pulse  = pulse_q;
  assign conflict_sticky = sticky_q;
  assign conflict_count  = count_q;

endmodule

// File: tb/tb_multi_driver_arbiter.sv
// Directed and randomised checks of multi_driver_arbiter against a cycle model and output scoreboard;
// a second instance with a 2-bit counter covers saturation.
module tb_multi_driver_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  drv_valid;
  logic [31:0] drv_data;
  logic        out_ready;
  logic        clear_conflict;

  logic [3:0]  drv_ready, drv_ready2;
  logic        out_valid, out_valid2;
  logic [7:0]  out_data, out_data2;
  logic [1:0]  grant_id, grant_id2;
  logic        conflict_pulse, conflict_pulse2;
  logic        conflict_sticky, conflict_sticky2;
  logic [7:0]  conflict_count;
  logic [1:0]  conflict_count2;

  multi_driver_arbiter #(.NUM_DRV(4), .WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .drv_valid(drv_valid), .drv_data(drv_data),
    .drv_ready(drv_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_id(grant_id), .conflict_pulse(conflict_pulse),
    .conflict_sticky(conflict_sticky), .conflict_count(conflict_count),
    .clear_conflict(clear_conflict)
  );

  multi_driver_arbiter #(.NUM_DRV(4), .WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .drv_valid(drv_valid), .drv_data(drv_data),
    .drv_ready(drv_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(out_ready), .grant_id(grant_id2), .conflict_pulse(conflict_pulse2),
    .conflict_sticky(conflict_sticky2), .conflict_count(conflict_count2),
    .clear_conflict(clear_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_rr;
  logic       m_pulse;
  logic       m_sticky;
  int         m_cnt;
  int         m_cnt2;
  logic [7:0] m_last_d;
  logic [1:0] m_last_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_rr      = 0;
    m_pulse   = 1'b0;
    m_sticky  = 1'b0;
    m_cnt     = 0;
    m_cnt2    = 0;
    m_last_d  = 8'h00;
    m_last_id = 2'd0;
  endtask

  // One clock cycle: drive inputs, check current outputs and combinational ready, advance the model.
  task automatic tick(input logic [3:0] v, input logic [31:0] d, input logic rdy, input logic clr);
    logic [3:0] exp_ready;
    logic       conf;
    int         g;
    logic       full;
    exp_t       e;
    drv_valid      = v;
    drv_data       = d;
    out_ready      = rdy;
    clear_conflict = clr;
    #1;
    full = (sb_q.size() != 0);
    chk("out_valid", out_valid, full);
    if (full) begin
      chk("out_data", out_data, sb_q[0].d);
      chk("grant_id", grant_id, sb_q[0].id);
    end else begin
      chk("idle_out_data", out_data, m_last_d);
      chk("idle_grant_id", grant_id, m_last_id);
    end
    chk("conflict_pulse", conflict_pulse, m_pulse);
    chk("conflict_sticky", conflict_sticky, m_sticky);
    chk("conflict_count", conflict_count, m_cnt);
    chk("sat_count", conflict_count2, m_cnt2);

    exp_ready = 4'b0000;
    g = -1;
    if ((!full || rdy) && (v != 4'b0000)) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && v[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      end
      exp_ready[g] = 1'b1;
    end
    chk("drv_ready", drv_ready, exp_ready);
    chk("sat_drv_ready", drv_ready2, exp_ready);

    if (full && rdy) void'(sb_q.pop_front());
    if (g >= 0) begin
      e.d  = d[g*8 +: 8];
      e.id = 2'(g);
      sb_q.push_back(e);
      m_last_d  = e.d;
      m_last_id = e.id;
      m_rr = (g + 1) % 4;
    end

    conf = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[i] && v[j] && (d[i*8 +: 8] != d[j*8 +: 8])) conf = 1'b1;
    m_pulse = conf;
    if (clr) begin
      m_sticky = conf;
      m_cnt    = conf ? 1 : 0;
      m_cnt2   = conf ? 1 : 0;
    end else if (conf) begin
      m_sticky = 1'b1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    drv_valid      = 4'b1111;
    drv_data       = 32'h0403_0201;
    out_ready      = 1'b1;
    clear_conflict = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_pulse", conflict_pulse, 1'b0);
    chk("rst_sticky", conflict_sticky, 1'b0);
    chk("rst_count", conflict_count, 8'd0);
    chk("rst_drv_ready", drv_ready, 4'b0000);
    rst_n = 1'b1;

    // Round-robin fairness with identical data: grants 0,1,2,3,0 and no conflicts
    for (int n = 0; n < 5; n++) tick(4'b1111, 32'h3C3C_3C3C, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);

    // Single driver
    tick(4'b0010, 32'h0000_A500, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);

    // Three conflict cycles, then a quiet cycle, then clear in a quiet cycle
    for (int n = 0; n < 3; n++) tick(4'b0011, 32'h0000_0201, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b1);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);

    // Backpressure: hold output for five cycles, then release
    tick(4'b1111, 32'h4433_2211, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) tick(4'b1111, 32'h4433_2211, 1'b0, 1'b0);
    tick(4'b1111, 32'h4433_2211, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);

    // Saturation of the 2-bit counter, then clear racing a conflict
    for (int n = 0; n < 5; n++) tick(4'b0101, 32'h0077_0066, 1'b1, 1'b0);
    tick(4'b0101, 32'h0077_0066, 1'b1, 1'b1);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);

    // Randomised traffic with a small data alphabet
    for (int n = 0; n < 40; n++) begin
      logic [31:0] rd;
      for (int b = 0; b < 4; b++) rd[b*8 +: 8] = 8'($urandom_range(0, 2));
      tick(4'($urandom_range(0, 15)), rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset while FULL with sticky set
    tick(4'b0011, 32'h0000_0201, 1'b1, 1'b0);
    tick(4'b0011, 32'h0000_0201, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_sticky", conflict_sticky, 1'b0);
    chk("async_count", conflict_count, 8'd0);
    chk("async_drv_ready", drv_ready, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick(4'b1111, 32'h3C3C_3C3C, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);
    tick(4'b0000, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_driver_arbiter.md
Name: multi_driver_arbiter

Overview:
- Resolves several candidate drivers of one shared signal into a single registered, conflict-free driver.
- Sits directly upstream of the shared-signal consumer. It replaces ad-hoc multiple assignments with a round-robin grant over a valid/ready handshake.
- Detects and counts cycles where more than one driver asserts valid with differing data, so multi-driver conflicts are visible in hardware and in simulation.

Parameters:
- NUM_DRV, 4, number of requesting drivers (2..8).
- WIDTH, 8, data width of each driver and of the output.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- drv_valid  input  NUM_DRV  per-driver request.
- drv_data  input  NUM_DRV*WIDTH  driver i occupies bits [i*WIDTH +: WIDTH].
- drv_ready  output  NUM_DRV  one-hot or zero; high for the granted driver when its transfer is accepted.
- out_valid  output  1  registered output holds valid data.
- out_data  output  WIDTH  registered resolved value.
- out_ready  input  1  downstream accepts out_data.
- grant_id  output  $clog2(NUM_DRV)  index of the driver that produced the current out_data.
- conflict_pulse  output  1  registered, one-cycle pulse per conflict cycle.
- conflict_sticky  output  1  set on any conflict, held until clear.
- conflict_count  output  CNT_W  saturating count of conflict cycles.
- clear_conflict  input  1  synchronous clear of the sticky flag and the counter.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_data=0, grant_id=0, rr_ptr=0, conflict_pulse=0, conflict_sticky=0, conflict_count=0.
- FSM states:
  - IDLE: out_valid=0.
  - FULL: out_valid=1, out_data held stable until out_ready.
- can_accept = (state==IDLE) || out_ready.
- Arbitration (combinational):
  - Scan drv_valid starting at index rr_ptr, wrapping modulo NUM_DRV. The first valid index is g.
  - drv_ready[g] = can_accept && |drv_valid. All other drv_ready bits are 0.
  - drv_ready never depends on drv_data.
- Accept (drv_ready[g]=1):
  - Next cycle: out_data=drv_data[g], grant_id=g, state=FULL.
  - rr_ptr = (g+1) mod NUM_DRV.
  - Latency is one cycle from accept to out_valid.
- FULL && out_ready && no drv_valid: next state IDLE, out_valid=0. out_data retains its last value.
- FULL && out_ready && some drv_valid: back-to-back transfer; remain FULL with new data. Full throughput is one transfer per cycle.
- FULL && !out_ready: all drv_ready=0; out_data and grant_id stable; rr_ptr unchanged.
- No drv_valid: rr_ptr unchanged.
- Conflict detection:
  - Evaluated every cycle, independent of the handshake.
  - conflict = at least two drivers valid whose drv_data values differ.
  - Two or more valid drivers with identical data is not a conflict.
- conflict_pulse is registered: it is high in cycle t+1 exactly when conflict was true in cycle t.
- conflict_count increments by 1 per conflict cycle and saturates at 2^CNT_W-1. It never wraps.
- conflict_sticky sets on conflict.
- clear_conflict:
  - Zeroes count and sticky next cycle.
  - If clear_conflict and a conflict occur in the same cycle: count=1, sticky=1 (the new event is not lost).
  - Does not affect conflict_pulse.
- Reset mid-transfer: out_valid drops immediately (asynchronous). Any in-flight data is discarded; no drv_ready is issued while rst_n=0.
- NUM_DRV=1: no conflicts are possible; the arbiter degenerates to a one-entry pipeline register.

Test Plan:
- Single driver: drv_valid=4'b0010, drv_data[1]=8'hA5, out_ready=1 -> drv_ready=4'b0010; next cycle out_valid=1, out_data=8'hA5, grant_id=1; no conflict_pulse.
- Round-robin fairness: all four drivers valid continuously with identical data 8'h3C, out_ready=1 -> grant_id sequence 0,1,2,3,0; conflict_count stays 0.
- Conflict: drv_valid=4'b0011, data 8'h01 and 8'h02 for 3 cycles -> conflict_pulse high for 3 cycles (each delayed one cycle), conflict_count=3, sticky=1. clear_conflict in a quiet cycle -> count=0, sticky=0.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles while drivers are valid -> drv_ready=0, out_data stable. Raise out_ready -> next granted driver accepted the same cycle.
- Saturation/clear race: CNT_W=2 with 5 consecutive conflict cycles -> count holds at 3. clear_conflict coincident with a conflict -> count=1, sticky=1.
- Async reset while FULL: assert rst_n=0 mid-cycle -> out_valid, conflict_sticky and conflict_count read 0 before the next clk edge; after release, rr_ptr=0.
